// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: divides clk into a pixel enable and runs the
// horizontal/vertical raster with registered, skew-free sync/bright/strobe outputs.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       pix_ce,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       bright,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned CW      = 10;
    localparam int unsigned XW      = CW + 1;
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CW-1:0]    H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0]    V_LAST   = CW'(V_TOTAL - 1);
    // Decode bounds carry one extra bit so an end bound of 1024 stays exact.
    localparam logic [XW-1:0]    HS_LO    = XW'(H_VISIBLE + H_FP);
    localparam logic [XW-1:0]    HS_HI    = XW'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [XW-1:0]    VS_LO    = XW'(V_VISIBLE + V_FP);
    localparam logic [XW-1:0]    VS_HI    = XW'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [XW-1:0]    H_VIS    = XW'(H_VISIBLE);
    localparam logic [XW-1:0]    V_VIS    = XW'(V_VISIBLE);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic             pix_ce_nxt;
    logic             adv;
    logic             h_wrap;
    logic             v_wrap;
    logic [CW-1:0]    h_nxt;
    logic [CW-1:0]    v_nxt;
    logic [XW-1:0]    h_ext;
    logic [XW-1:0]    v_ext;
    logic             hs_nxt;
    logic             vs_nxt;
    logic             br_nxt;
    logic             ls_nxt;
    logic             fs_nxt;

    // Clock divider: div holds while en is low, so a resume continues the phase.
    always_comb begin
        div_nxt    = div;
        pix_ce_nxt = 1'b0;
        if (en) begin
            pix_ce_nxt = (div == DIV_LAST);
            div_nxt    = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
        end
    end

    // Raster next state; sync/bright decode from the next counts so they move with them.
    always_comb begin
        adv    = pix_ce & en;
        h_wrap = (hcount == H_LAST);
        v_wrap = (vcount == V_LAST);
        h_nxt  = hcount;
        v_nxt  = vcount;
        if (adv) begin
            if (h_wrap) begin
                h_nxt = '0;
                v_nxt = v_wrap ? '0 : vcount + CW'(1);
            end else begin
                h_nxt = hcount + CW'(1);
            end
        end
        h_ext  = {1'b0, h_nxt};
        v_ext  = {1'b0, v_nxt};
        hs_nxt = ((h_ext >= HS_LO) && (h_ext < HS_HI)) ? SYNC_POL : ~SYNC_POL;
        vs_nxt = ((v_ext >= VS_LO) && (v_ext < VS_HI)) ? SYNC_POL : ~SYNC_POL;
        br_nxt = (h_ext < H_VIS) && (v_ext < V_VIS);
        ls_nxt = adv & h_wrap;
        fs_nxt = adv & h_wrap & v_wrap;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div         <= '0;
            pix_ce      <= 1'b0;
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            bright      <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div         <= div_nxt;
            pix_ce      <= pix_ce_nxt;
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            hsync       <= hs_nxt;
            vsync       <= vs_nxt;
            bright      <= br_nxt;
            line_start  <= ls_nxt;
            frame_start <= fs_nxt;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing instance plus two small rasters,
// checked every clock against a pixel-index scoreboard model and at table checkpoints.
module tb_vga_timing_gen;

    localparam int NI = 3;

    typedef struct packed {
        logic       ce;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       br;
        logic       ls;
        logic       fs;
    } exp_t;

    typedef exp_t [NI-1:0] expv_t;

    typedef struct {
        string       name;
        int unsigned clks;
        bit          en;
        exp_t        e;
    } vec_t;

    localparam int unsigned P_CD  [NI] = '{4, 3, 1};
    localparam int unsigned P_HV  [NI] = '{640, 8, 5};
    localparam int unsigned P_HFP [NI] = '{16, 2, 1};
    localparam int unsigned P_HS  [NI] = '{96, 3, 2};
    localparam int unsigned P_HBP [NI] = '{48, 2, 1};
    localparam int unsigned P_VV  [NI] = '{480, 6, 3};
    localparam int unsigned P_VFP [NI] = '{10, 1, 1};
    localparam int unsigned P_VS  [NI] = '{2, 2, 1};
    localparam int unsigned P_VBP [NI] = '{33, 1, 1};
    localparam bit          P_POL [NI] = '{1'b0, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       o_ce [NI];
    logic [9:0] o_h  [NI];
    logic [9:0] o_v  [NI];
    logic       o_hs [NI];
    logic       o_vs [NI];
    logic       o_br [NI];
    logic       o_ls [NI];
    logic       o_fs [NI];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_dut0 (
        .clk(clk), .rst(rst), .en(en), .pix_ce(o_ce[0]), .hcount(o_h[0]), .vcount(o_v[0]),
        .hsync(o_hs[0]), .vsync(o_vs[0]), .bright(o_br[0]), .line_start(o_ls[0]),
        .frame_start(o_fs[0])
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .pix_ce(o_ce[1]), .hcount(o_h[1]), .vcount(o_v[1]),
        .hsync(o_hs[1]), .vsync(o_vs[1]), .bright(o_br[1]), .line_start(o_ls[1]),
        .frame_start(o_fs[1])
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_VISIBLE(5), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b0)
    ) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .pix_ce(o_ce[2]), .hcount(o_h[2]), .vcount(o_v[2]),
        .hsync(o_hs[2]), .vsync(o_vs[2]), .bright(o_br[2]), .line_start(o_ls[2]),
        .frame_start(o_fs[2])
    );

    function automatic exp_t decode(input int g, input bit ce, input int unsigned pix,
                                    input bit ls, input bit fs);
        exp_t        e;
        int unsigned ht;
        int unsigned h;
        int unsigned v;
        ht   = P_HV[g] + P_HFP[g] + P_HS[g] + P_HBP[g];
        h    = pix % ht;
        v    = pix / ht;
        e.ce = ce;
        e.h  = 10'(h);
        e.v  = 10'(v);
        e.hs = (h >= P_HV[g] + P_HFP[g] && h < P_HV[g] + P_HFP[g] + P_HS[g]) ? P_POL[g] : ~P_POL[g];
        e.vs = (v >= P_VV[g] + P_VFP[g] && v < P_VV[g] + P_VFP[g] + P_VS[g]) ? P_POL[g] : ~P_POL[g];
        e.br = (h < P_HV[g]) && (v < P_VV[g]);
        e.ls = ls;
        e.fs = fs;
        return e;
    endfunction

    function automatic exp_t reset_exp(input int g);
        exp_t e;
        e    = '0;
        e.hs = ~P_POL[g];
        e.vs = ~P_POL[g];
        e.br = 1'b1;
        return e;
    endfunction

    function automatic exp_t actual(input int g);
        exp_t a;
        a.ce = o_ce[g];
        a.h  = o_h[g];
        a.v  = o_v[g];
        a.hs = o_hs[g];
        a.vs = o_vs[g];
        a.br = o_br[g];
        a.ls = o_ls[g];
        a.fs = o_fs[g];
        return a;
    endfunction

    function automatic string fmt(input exp_t e);
        return $sformatf("ce=%b h=%0d v=%0d hs=%b vs=%b br=%b ls=%b fs=%b",
                         e.ce, e.h, e.v, e.hs, e.vs, e.br, e.ls, e.fs);
    endfunction

    // Reference model: linear pixel index per instance, stepped on each rising edge.
    int unsigned m_div [NI];
    int unsigned m_pix [NI];
    bit          m_ce  [NI];
    expv_t       sbq   [$];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int g = 0; g < NI; g++) begin
                m_div[g] = 0;
                m_pix[g] = 0;
                m_ce[g]  = 1'b0;
            end
            sbq.delete();
        end else begin
            expv_t       ev;
            int unsigned ht;
            int unsigned tot;
            bit          adv;
            bit          ls;
            bit          fs;
            for (int g = 0; g < NI; g++) begin
                ht  = P_HV[g] + P_HFP[g] + P_HS[g] + P_HBP[g];
                tot = ht * (P_VV[g] + P_VFP[g] + P_VS[g] + P_VBP[g]);
                adv = m_ce[g] && en;
                ls  = adv && (m_pix[g] % ht == ht - 1);
                fs  = adv && (m_pix[g] == tot - 1);
                if (adv) m_pix[g] = (m_pix[g] + 1) % tot;
                m_ce[g] = en && (m_div[g] == P_CD[g] - 1);
                if (en) m_div[g] = (m_div[g] + 1) % P_CD[g];
                ev[g] = decode(g, m_ce[g], m_pix[g], ls, fs);
            end
            sbq.push_back(ev);
        end
    end

    task automatic finish_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic cmp(input string name, input int g, input exp_t a, input exp_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t actual {%s} expected {%s}", name, g, $time, fmt(a), fmt(e));
        end
    endtask

    task automatic cmp_int(input string name, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s t=%0t actual %0d expected %0d", name, $time, a, e);
        end
    endtask

    // One clock: wait for the falling edge and retire the scoreboard entry for it.
    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            if (sbq.size() != 0) begin
                expv_t ev;
                ev = sbq.pop_front();
                for (int g = 0; g < NI; g++) cmp("scoreboard", g, actual(g), ev[g]);
            end
            if (errors >= 25) finish_run();
        end
    endtask

    vec_t tbl [$];

    task automatic add(input string name, input int unsigned clks, input int unsigned h,
                       input int unsigned v, input bit hs, input bit br, input bit ls);
        vec_t r;
        r.name = name;
        r.clks = clks;
        r.en   = 1'b1;
        r.e    = '0;
        r.e.h  = 10'(h);
        r.e.v  = 10'(v);
        r.e.hs = hs;
        r.e.vs = 1'b1;
        r.e.br = br;
        r.e.ls = ls;
        tbl.push_back(r);
    endtask

    initial begin
        int  n;
        bit  seen;
        rst = 1'b1;
        en  = 1'b0;
        #1 rst = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) cmp("power_on_reset", g, actual(g), reset_exp(g));
        @(negedge clk);
        rst = 1'b1;
        tick(2);
        for (int g = 0; g < NI; g++) cmp("idle_en_low", g, actual(g), reset_exp(g));

        // Default instance, clock counts are relative to the previous row.
        add("first_edge",      1,     0,   0,  1, 1, 0);
        add("h1_first_ce",     4,     1,   0,  1, 1, 0);
        add("h639_bright",     2552,  639, 0,  1, 1, 0);
        add("h640_dark",       4,     640, 0,  1, 0, 0);
        add("h655_pre_hsync",  60,    655, 0,  1, 0, 0);
        add("h656_hsync_on",   4,     656, 0,  0, 0, 0);
        add("h751_hsync_last", 380,   751, 0,  0, 0, 0);
        add("h752_hsync_off",  4,     752, 0,  1, 0, 0);
        add("h799_eol",        188,   799, 0,  1, 0, 0);
        add("line_wrap_v1",    4,     0,   1,  1, 1, 1);
        add("ls_clear_v1",     1,     0,   1,  1, 1, 0);
        add("h799_v10",        31995, 799, 10, 1, 0, 0);
        add("line_wrap_v11",   4,     0,   11, 1, 1, 1);
        add("ls_clear_v11",    1,     0,   11, 1, 1, 0);
        add("h100_v11",        399,   100, 11, 1, 1, 0);

        foreach (tbl[i]) begin
            en = tbl[i].en;
            tick(tbl[i].clks);
            cmp(tbl[i].name, 0, actual(0), tbl[i].e);
        end

        // Freeze at h=100 with the divider at phase 1, then resume.
        en = 1'b0;
        tick(37);
        begin
            exp_t e;
            e    = '0;
            e.h  = 10'd100;
            e.v  = 10'd11;
            e.hs = 1'b1;
            e.vs = 1'b1;
            e.br = 1'b1;
            cmp("frozen_h100", 0, actual(0), e);
        end
        en = 1'b1;
        n  = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            tick(1);
            n++;
            seen = o_ce[0];
        end
        cmp_int("resume_ce_latency", n, 3);
        tick(1);
        cmp_int("resume_h101", int'(o_h[0]), 101);

        // Random enable toggling exercises en falling on strobes and pixel enables.
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom_range(0, 3) != 0);
            tick(1);
        end

        // Asynchronous mid-frame reset, away from any clock edge.
        en = 1'b1;
        tick(700);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) cmp("async_reset", g, actual(g), reset_exp(g));
        tick(1);
        for (int g = 0; g < NI; g++) cmp("held_in_reset", g, actual(g), reset_exp(g));
        rst = 1'b1;

        // First frame wrap of the small polarity-high instance.
        n = 0;
        seen = 1'b0;
        while (!seen && n < 1000) begin
            tick(1);
            n++;
            seen = o_fs[1];
        end
        cmp_int("frame_start_seen", int'(seen), 1);
        cmp_int("frame_wrap_h", int'(o_h[1]), 0);
        cmp_int("frame_wrap_v", int'(o_v[1]), 0);
        cmp_int("frame_wrap_ls", int'(o_ls[1]), 1);
        tick(1);
        cmp_int("frame_start_clear", int'(o_fs[1]), 0);

        tick(2000);
        finish_run();
    end

endmodule
